// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmit and receive paths.
//   tx_state_e   host transmitter FSM encoding
//   ERR_*        err_code values reported with the error pulse
//   CMD_*        common host-to-mouse command bytes
//   odd_parity   parity bit that makes the data byte plus parity contain an odd number of ones
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RTS       = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } tx_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_NOACK   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/status bundle between a command source and ps2_host_tx.
//   tx_data/tx_valid   byte and request from the command source
//   tx_ready           transmitter idle, request will be taken
//   busy               transfer in progress (receive path should ignore the lines)
//   done/error         one-cycle completion pulses
//   err_code           cause of the last error, held between errors
// Modports: master = command source, slave = transmitter.
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, error, err_code
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, error, err_code
   );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data pins into the clk domain.
//   clk, rst_n          system clock, async active-low reset
//   clk_in, data_in     raw pin levels
//   clk_sync, data_sync two-flop synchronised levels
//   clk_fe, data_fe     high for one cycle when the synchronised level goes 1 -> 0
// Flops reset to 1 because idle open-drain lines float high; this keeps a
// reset from being seen as a falling edge.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic data_in,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fe,
   output logic data_fe
);

   // [0] metastability stage, [1] synchronised level, [2] previous synchronised level
   logic [2:0] clk_pipe_r;
   logic [2:0] data_pipe_r;

   // Shift both pins through the synchroniser and edge-history flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_pipe_r  <= 3'b111;
         data_pipe_r <= 3'b111;
      end else begin
         clk_pipe_r  <= {clk_pipe_r[1:0], clk_in};
         data_pipe_r <= {data_pipe_r[1:0], data_in};
      end
   end

   assign clk_sync  = clk_pipe_r[1];
   assign data_sync = data_pipe_r[1];
   assign clk_fe    = clk_pipe_r[2] & ~clk_pipe_r[1];
   assign data_fe   = data_pipe_r[2] & ~data_pipe_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 mouse.
//   clk, rst_n            system clock, async active-low reset (releases both lines at once)
//   tx_if (slave)         request/status bundle, see ps2_host_tx_if
//   ps2_clk_in/data_in    raw mouse_clk / mouse_data pin levels
//   ps2_*_drive_low       1 = pull the open-drain line low, 0 = release
// Sequence: hold clock low INHIBIT_CYCLES, pull data low (start bit), release
// clock, then on each device clock falling edge present d0..d7, parity, stop,
// and finally check the device's acknowledge bit.
// Optional feature: define PS2_TX_TIMEOUT_EN to abort any transfer that has not
// finished TIMEOUT_CYCLES after it was accepted (err_code ERR_TIMEOUT).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   ps2_host_tx_if.slave tx_if,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_drive_low,
   output logic         ps2_data_drive_low
);

   // The counter stops at the larger limit so it can never wrap back into a compare value.
   localparam int unsigned     CNT_MAX      = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_INH_LAST = CNT_W'(INHIBIT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_INH_PEN  = CNT_W'(INHIBIT_CYCLES - 32'd2);
`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
`endif
   // With a one-cycle inhibit the start bit must already appear in the first inhibit cycle.
   localparam logic             INH_SINGLE   = (INHIBIT_CYCLES == 32'd1);

   logic clk_sync_s, data_sync_s, clk_fe_s;
   logic data_fe_unused_s;   // data edges are only consumed by the receive path

   tx_state_e        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [3:0]       bit_idx_r, bit_idx_s;
   logic [9:0]       frame_r, frame_s;      // {stop, parity, data[7:0]}, sent LSB first
   logic             clk_dl_r, clk_dl_s;
   logic             data_dl_r, data_dl_s;
   logic             busy_r, busy_s;
   logic             ready_r, ready_s;
   logic             done_r, done_s;
   logic             error_r, error_s;
   logic [1:0]       err_code_r, err_code_s;

   ps2_line_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_in    (ps2_clk_in),
      .data_in   (ps2_data_in),
      .clk_sync  (clk_sync_s),
      .data_sync (data_sync_s),
      .clk_fe    (clk_fe_s),
      .data_fe   (data_fe_unused_s)
   );

   // State, counter, frame and all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         bit_idx_r  <= 4'd0;
         frame_r    <= 10'd0;
         clk_dl_r   <= 1'b0;
         data_dl_r  <= 1'b0;
         busy_r     <= 1'b0;
         ready_r    <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_code_r <= ERR_NONE;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         bit_idx_r  <= bit_idx_s;
         frame_r    <= frame_s;
         clk_dl_r   <= clk_dl_s;
         data_dl_r  <= data_dl_s;
         busy_r     <= busy_s;
         ready_r    <= ready_s;
         done_r     <= done_s;
         error_r    <= error_s;
         err_code_r <= err_code_s;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_s    = state_r;
      bit_idx_s  = bit_idx_r;
      frame_s    = frame_r;
      clk_dl_s   = clk_dl_r;
      data_dl_s  = data_dl_r;
      busy_s     = busy_r;
      ready_s    = ready_r;
      done_s     = 1'b0;
      error_s    = 1'b0;
      err_code_s = err_code_r;
      if (cnt_r != CNT_SAT) begin
         cnt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_s = cnt_r;
      end

      case (state_r)
         ST_IDLE: begin
            clk_dl_s  = 1'b0;
            data_dl_s = 1'b0;
            busy_s    = 1'b0;
            ready_s   = 1'b1;
            cnt_s     = CNT_ZERO;   // counts from the first inhibit cycle
            if (tx_if.tx_valid && ready_r) begin
               frame_s   = {1'b1, odd_parity(tx_if.tx_data), tx_if.tx_data};
               state_s   = ST_INHIBIT;
               clk_dl_s  = 1'b1;
               data_dl_s = INH_SINGLE;
               busy_s    = 1'b1;
               ready_s   = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_INHIBIT: begin
            if (cnt_r == CNT_INH_LAST) begin
               state_s   = ST_RTS;
               clk_dl_s  = 1'b0;
               data_dl_s = 1'b1;
            end else begin
               clk_dl_s  = 1'b1;
               // Start bit lands on the last inhibit cycle.
               data_dl_s = (cnt_r == CNT_INH_PEN);
            end
         end
         ST_RTS: begin
            clk_dl_s = 1'b0;
            if (clk_fe_s) begin
               data_dl_s = ~frame_r[0];
               bit_idx_s = 4'd1;
               state_s   = ST_SHIFT;
            end else begin
               data_dl_s = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (clk_fe_s) begin
               data_dl_s = ~frame_r[bit_idx_r];
               if (bit_idx_r == 4'd9) begin
                  state_s = ST_ACK;
               end else begin
                  bit_idx_s = bit_idx_r + 4'd1;
               end
            end else begin
               data_dl_s = data_dl_r;
            end
         end
         ST_ACK: begin
            if (clk_fe_s) begin
               if (data_sync_s == 1'b0) begin
                  state_s = ST_WAIT_IDLE;
               end else begin
                  state_s    = ST_IDLE;
                  error_s    = 1'b1;
                  err_code_s = ERR_NOACK;
                  clk_dl_s   = 1'b0;
                  data_dl_s  = 1'b0;
                  busy_s     = 1'b0;
                  ready_s    = 1'b0;
               end
            end else begin
               state_s = ST_ACK;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_sync_s && data_sync_s) begin
               state_s   = ST_IDLE;
               done_s    = 1'b1;
               clk_dl_s  = 1'b0;
               data_dl_s = 1'b0;
               busy_s    = 1'b0;
               ready_s   = 1'b0;
            end else begin
               state_s = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            clk_dl_s  = 1'b0;
            data_dl_s = 1'b0;
            busy_s    = 1'b0;
            ready_s   = 1'b0;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides whatever the state wanted, including a done in the same cycle.
      if ((state_r != ST_IDLE) && (cnt_r == CNT_TO_LAST)) begin
         state_s    = ST_IDLE;
         done_s     = 1'b0;
         error_s    = 1'b1;
         err_code_s = ERR_TIMEOUT;
         clk_dl_s   = 1'b0;
         data_dl_s  = 1'b0;
         busy_s     = 1'b0;
         ready_s    = 1'b0;
      end else begin
         err_code_s = err_code_s;
      end
`endif
   end

   assign tx_if.tx_ready     = ready_r;
   assign tx_if.busy         = busy_r;
   assign tx_if.done         = done_r;
   assign tx_if.error        = error_r;
   assign tx_if.err_code     = err_code_r;
   assign ps2_clk_drive_low  = clk_dl_r;
   assign ps2_data_drive_low = data_dl_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx with a PS/2 device model.
// Stimulus pushes the expected outcome of each transfer into exp_q; a monitor on
// the falling clock edge pops and compares whenever done or error pulses.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 20;
   localparam int TO   = 3000;
   localparam int HALF = 8;      // device clock half period in system clocks
   localparam int PER  = 10;

   localparam int M_ACK   = 0;
   localparam int M_NOACK = 1;
   localparam int M_NOCLK = 2;
   localparam int M_ABORT = 3;
   localparam logic [1:0] CODE_NOCLK = ERR_TIMEOUT;

   typedef struct {
      logic       is_err;
      logic [1:0] code;
      logic       has_frame;
      logic [9:0] frame;
      longint     acc_t;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic ps2_clk_drive_low, ps2_data_drive_low;
   logic ps2_clk_in_w, ps2_data_in_w;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0;
   logic pending_next = 1'b0;
   logic [1:0] last_code = ERR_NONE;
   exp_t exp_q[$];
   logic [9:0] dev_rx_q[$];

   ps2_host_tx_if tx_if ();

   assign ps2_clk_in_w  = dev_clk & ~ps2_clk_drive_low;
   assign ps2_data_in_w = dev_data & ~ps2_data_drive_low;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(12)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .tx_if              (tx_if),
      .ps2_clk_in         (ps2_clk_in_w),
      .ps2_data_in        (ps2_data_in_w),
      .ps2_clk_drive_low  (ps2_clk_drive_low),
      .ps2_data_drive_low (ps2_data_drive_low)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Reference frame: data LSB first, then a parity bit making the total ones count odd, then stop = 1.
   function automatic logic [9:0] ref_frame(input logic [7:0] d);
      int ones;
      ones = $countones(d);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input int mode);
      exp_t e;
      int n;
      n = 0;
      while (!tx_if.tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", tx_if.tx_ready, 1);
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
      @(posedge clk);
      e.acc_t     = $time;
      e.is_err    = (mode != M_ACK);
      e.code      = (mode == M_NOACK) ? ERR_NOACK : CODE_NOCLK;
      e.has_frame = (mode != M_NOCLK);
      e.frame     = ref_frame(d);
      if (mode != M_ABORT) exp_q.push_back(e);
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = ~d;
      // A request while busy must be ignored.
      repeat (3) @(negedge clk);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'($urandom);
      repeat (3) @(negedge clk);
      tx_if.tx_valid = 1'b0;
   endtask

   task automatic device(input int mode);
      int n;
      int cnt;
      int nlow;
      int low_at;
      logic [9:0] bits;
      n = 0;
      while (!ps2_clk_drive_low && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("inhibit_start", ps2_clk_drive_low, 1);
      cnt = 0; nlow = 0; low_at = -1;
      while (ps2_clk_drive_low && cnt < INH + 50) begin
         if (ps2_data_drive_low) begin
            nlow++;
            low_at = cnt;
         end
         cnt++;
         @(negedge clk);
      end
      chk("inhibit_len", cnt, INH);
      chk("start_low_count", nlow, 1);
      chk("start_low_cycle", low_at, INH - 1);
      chk("rts_data_low", ps2_data_drive_low, 1);
      if (mode == M_NOCLK) return;
      bits = 10'd0;
      for (int i = 0; i < 10; i++) begin
         wait_cyc(HALF);
         dev_clk = 1'b0;
         wait_cyc(HALF);
         dev_clk = 1'b1;
         bits[i] = ps2_data_in_w;
         if (mode == M_ABORT && i == 3) return;
      end
      dev_rx_q.push_back(bits);
      wait_cyc(HALF / 2);
      if (mode == M_ACK) dev_data = 1'b0;
      wait_cyc(HALF - HALF / 2);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(2);
      dev_data = 1'b1;
   endtask

   task automatic wait_resp(input int target);
      int n;
      n = 0;
      while (resp_cnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("resp_timeout", (resp_cnt >= target), 1);
   endtask

   task automatic xfer(input logic [7:0] d, input int mode);
      int target;
      target = resp_cnt + 1;
      fork
         send(d, mode);
         device(mode);
      join
      wait_resp(target);
   endtask

   // Monitor: pops the scoreboard on every done/error pulse.
   always @(negedge clk) begin
      exp_t e;
      logic [9:0] got;
      if (rst_n && (tx_if.done || tx_if.error)) begin
         resp_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            e = exp_q.pop_front();
            if (e.is_err) last_code = e.code;
            chk("resp_is_error", tx_if.error, e.is_err);
            chk("resp_is_done", tx_if.done, !e.is_err);
            chk("err_code", tx_if.err_code, last_code);
            chk("busy_at_resp", tx_if.busy, 0);
            chk("ready_at_resp", tx_if.tx_ready, 0);
            chk("clk_released", ps2_clk_drive_low, 0);
            chk("data_released", ps2_data_drive_low, 0);
            if (e.has_frame) begin
               if (dev_rx_q.size() == 0) begin
                  chk("frame_missing", 1, 0);
               end else begin
                  got = dev_rx_q.pop_front();
                  chk("frame_bits", got, e.frame);
               end
            end
            if (e.is_err && e.code == ERR_TIMEOUT) begin
               chk("timeout_latency", 32'($time - e.acc_t), TO * PER + PER / 2);
            end
            pending_next = 1'b1;
         end
      end else if (pending_next) begin
         pending_next = 1'b0;
         chk("ready_after_resp", tx_if.tx_ready, 1);
         chk("pulse_one_cycle", (tx_if.done | tx_if.error), 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_if.tx_data  = 8'h00;
      tx_if.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_clk_dl", ps2_clk_drive_low, 0);
      chk("rst_data_dl", ps2_data_drive_low, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", tx_if.tx_ready, 1);
      chk("rst_busy", tx_if.busy, 0);
      chk("rst_done", tx_if.done, 0);
      chk("rst_error", tx_if.error, 0);
      chk("rst_err_code", tx_if.err_code, ERR_NONE);

      // Device clock activity while idle must not start anything.
      wait_cyc(2);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(HALF);
      chk("idle_ignore_busy", tx_if.busy, 0);
      chk("idle_ignore_clk", ps2_clk_drive_low, 0);

      xfer(CMD_ENABLE, M_ACK);
      xfer(CMD_RESET, M_ACK);
      xfer(8'h00, M_NOACK);
      for (int i = 0; i < 12; i++) begin
         xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK);
      end

      // Reset in the middle of the data bits.
      fork
         send(CMD_ENABLE, M_ABORT);
         device(M_ABORT);
      join
      chk("abort_pre_data_low", ps2_data_drive_low, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_clk_dl", ps2_clk_drive_low, 0);
      chk("abort_data_dl", ps2_data_drive_low, 0);
      chk("abort_busy", tx_if.busy, 0);
      exp_q.delete();
      dev_rx_q.delete();
      last_code = ERR_NONE;
      pending_next = 1'b0;
      tx_if.tx_valid = 1'b0;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(CMD_ENABLE, M_ACK);

`ifdef PS2_TX_TIMEOUT_EN
      xfer(8'($urandom), M_NOCLK);
      xfer(CMD_ENABLE, M_ACK);
`endif

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
